// File: rtl/scroll_display_ctrl.sv
// scroll_display_ctrl
//   Single-clock controller for a 4-digit scrolling message display. It holds a
//   writable symbol buffer, derives digit-scan and scroll timing from clock
//   enables, and registers the digit code and active-low anode select.
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   start / stop           pulses: begin scrolling / blank and return to IDLE
//   hold                   level: freeze scroll position, scanning continues
//   wr_en/wr_addr/wr_data  message buffer write port
//   len_we/len_data        message length write (values above MSG_DEPTH clamp)
//   digit_code, an         symbol and active-low anode for the enabled digit
//   running                high in RUN or PAUSE
//   wrap                   one-cycle pulse when the scroll position returns to 0
module scroll_display_ctrl #(
  parameter int REFRESH_DIV = 250000,
  parameter int SCROLL_DIV  = 100000000,
  parameter int MSG_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         hold,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [3:0]                   wr_data,
  input  logic                         len_we,
  input  logic [$clog2(MSG_DEPTH):0]   len_data,
  output logic [3:0]                   digit_code,
  output logic [3:0]                   an,
  output logic                         running,
  output logic                         wrap
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SCROLL_DIV);
  localparam logic [RW-1:0] REF_TC  = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCR_TC  = SW'(SCROLL_DIV - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MSG_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [MSG_DEPTH-1:0][3:0] mem_q;
  logic [LW-1:0]            len_q, len_d;
  logic [AW-1:0]            pos_q, pos_d, pos_l;
  logic [LW-1:0]            pos_inc;
  logic [1:0]               s_q, s_d, slot;
  logic [RW-1:0]            ref_q, ref_d;
  logic [SW-1:0]            scr_q, scr_d;
  logic [3:0]               an_q, an_d, code_q, code_d;
  logic                     running_q, wrap_q, wrap_d, load;

  // (p + k) mod l for p < l, k <= 3; the sum is below l + 3, so at most three
  // conditional subtractions are needed even for l = 1.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] p,
                                            input logic [1:0]    k,
                                            input logic [LW-1:0] l);
    logic [AW+1:0] v;
    v = {2'b00, p} + {{AW{1'b0}}, k};
    for (int i = 0; i < 3; i++)
      if (v >= {1'b0, l}) v = v - {1'b0, l};
    return v[AW-1:0];
  endfunction

  always_comb begin
    // Length write lands first; later decisions in this cycle see the new length.
    len_d = len_q;
    if (len_we) len_d = (len_data > LEN_MAX) ? LEN_MAX : len_data;
    pos_l = pos_q;
    if (len_we && ({1'b0, pos_q} >= len_d)) pos_l = '0;
    pos_inc = {1'b0, pos_l} + LW'(1);

    state_d = state_q;
    if (stop || len_d == '0) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (hold)  state_d = PAUSE;
        PAUSE:   if (!hold) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    ref_d  = ref_q;
    scr_d  = scr_q;
    s_d    = s_q;
    pos_d  = pos_l;
    an_d   = an_q;
    code_d = code_q;
    wrap_d = 1'b0;
    load   = 1'b0;
    slot   = s_q;

    if (state_d == IDLE) begin
      ref_d  = '0;
      scr_d  = '0;
      s_d    = '0;
      an_d   = 4'b1111;
      code_d = 4'd0;
    end else if (state_q == IDLE) begin
      // Entry: restart timing and show slot 0 right away.
      ref_d = '0;
      scr_d = '0;
      s_d   = '0;
      load  = 1'b1;
      slot  = 2'd0;
    end else begin
      if (ref_q == REF_TC) begin
        ref_d = '0;
        s_d   = s_q + 2'd1;
        load  = 1'b1;
        slot  = s_q + 2'd1;
      end else begin
        ref_d = ref_q + RW'(1);
      end
      // Scroll time only accumulates while actually running.
      if (state_q == RUN) begin
        if (scr_q == SCR_TC) begin
          scr_d  = '0;
          pos_d  = (pos_inc == len_d) ? '0 : pos_inc[AW-1:0];
          wrap_d = (pos_inc == len_d);
        end else begin
          scr_d = scr_q + SW'(1);
        end
      end
    end

    // Slot loads use the pre-step position; a step shows from the next load.
    if (load) begin
      an_d   = ~(4'b0001 << slot);
      code_d = mem_q[mod_add(pos_l, 2'd3 - slot, len_d)];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      pos_q     <= '0;
      s_q       <= '0;
      ref_q     <= '0;
      scr_q     <= '0;
      an_q      <= 4'b1111;
      code_q    <= 4'd0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pos_q     <= pos_d;
      s_q       <= s_d;
      ref_q     <= ref_d;
      scr_q     <= scr_d;
      an_q      <= an_d;
      code_q    <= code_d;
      running_q <= (state_d != IDLE);
      wrap_q    <= wrap_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      mem_q          <= '0;
    else if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign digit_code = code_q;
  assign an         = an_q;
  assign running    = running_q;
  assign wrap       = wrap_q;
endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Self-checking bench for scroll_display_ctrl with short timing periods.
module tb_scroll_display_ctrl;
  localparam int R = 4;
  localparam int S = 64;

  logic       clk = 1'b0;
  logic       reset, start, stop, hold, wr_en, len_we;
  logic [3:0] wr_addr, wr_data;
  logic [4:0] len_data;
  logic [3:0] digit_code, an;
  logic       running, wrap;

  scroll_display_ctrl #(.REFRESH_DIV(R), .SCROLL_DIV(S), .MSG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_we(len_we), .len_data(len_data),
    .digit_code(digit_code), .an(an), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: message state plus elapsed active / run cycles since entry.
  int         m_state;   // 0 idle, 1 run, 2 pause
  int         m_buf[16];
  int         m_len, m_pos, m_act, m_runc;
  logic [3:0] m_an, m_code;
  logic       m_wrap, m_running;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_len = 0; m_pos = 0; m_act = 0; m_runc = 0;
    for (int i = 0; i < 16; i++) m_buf[i] = 0;
    m_an = 4'hF; m_code = 4'h0; m_wrap = 1'b0; m_running = 1'b0;
  endtask

  task automatic show(input int s, input int p, input int l);
    m_an    = 4'hF;
    m_an[s] = 1'b0;
    m_code  = 4'(m_buf[(p + 3 - s) % l]);
  endtask

  task automatic model_tick();
    int nl, pl, ns;
    nl = len_we ? ((len_data > 16) ? 16 : int'(len_data)) : m_len;
    pl = (len_we && m_pos >= nl) ? 0 : m_pos;
    m_wrap = 1'b0;
    if (stop || nl == 0) ns = 0;
    else if (m_state == 0) ns = start ? 1 : 0;
    else ns = hold ? 2 : 1;
    if (ns == 0) begin
      m_an = 4'hF; m_code = 4'h0; m_act = 0; m_runc = 0;
    end else if (m_state == 0) begin
      m_act = 0; m_runc = 0;
      show(0, pl, nl);
    end else begin
      m_act++;
      if (m_act % R == 0) show((m_act / R) % 4, pl, nl);
      if (m_state == 1) begin
        m_runc++;
        if (m_runc % S == 0) begin
          pl = (pl + 1) % nl;
          m_wrap = (pl == 0);
        end
      end
    end
    m_pos = pl; m_len = nl; m_state = ns; m_running = (ns != 0);
    if (wr_en) m_buf[wr_addr] = int'(wr_data);
  endtask

  // One clock: advance model, take the edge, compare, drop the pulses.
  task automatic cyc();
    model_tick();
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(m_an));
    chk("digit_code", 32'(digit_code), 32'(m_code));
    chk("running", 32'(running), 32'(m_running));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    start = 1'b0; stop = 1'b0; wr_en = 1'b0; len_we = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 4'(d); cyc();
  endtask

  task automatic set_len(input int l);
    len_we = 1'b1; len_data = 5'(l); cyc();
  endtask

  initial begin
    int nwrap, wrap_at;
    reset = 1'b1; start = 0; stop = 0; hold = 0; wr_en = 0; len_we = 0;
    wr_addr = 0; wr_data = 0; len_data = 0;
    model_reset();
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_code", 32'(digit_code), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    #11 reset = 1'b0;

    // Six-symbol message, scan order and scroll timing.
    for (int i = 0; i < 6; i++) wr(i, i + 1);
    set_len(6);
    start = 1'b1; cyc();
    chk("entry_an", 32'(an), 32'hE);
    chk("entry_code", 32'(digit_code), 32'd4);
    nwrap = 0; wrap_at = -1;
    for (int k = 1; k <= 400; k++) begin
      cyc();
      if (wrap) begin nwrap++; wrap_at = k; end
      if (k == 4)   begin chk("s1_an", 32'(an), 32'hD); chk("s1_code", 32'(digit_code), 32'd3); end
      if (k == 8)   begin chk("s2_an", 32'(an), 32'hB); chk("s2_code", 32'(digit_code), 32'd2); end
      if (k == 12)  begin chk("s3_an", 32'(an), 32'h7); chk("s3_code", 32'(digit_code), 32'd1); end
      if (k == 16)  begin chk("s0_an", 32'(an), 32'hE); chk("s0_code", 32'(digit_code), 32'd4); end
      if (k == 336) begin chk("pos5_an", 32'(an), 32'hE); chk("pos5_code", 32'(digit_code), 32'd3); end
    end
    chk("wrap_count", 32'(nwrap), 32'd1);
    chk("wrap_cycle", 32'(wrap_at), 32'd384);

    // Hold freezes scrolling while scanning continues.
    hold = 1'b1;
    repeat (200) cyc();
    chk("hold_running", 32'(running), 32'h1);
    hold = 1'b0;
    repeat (100) cyc();

    // Asynchronous reset in the middle of a run.
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_code", 32'(digit_code), 32'h0);
    chk("mid_rst_running", 32'(running), 32'h0);
    chk("mid_rst_wrap", 32'(wrap), 32'h0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    set_len(4);
    start = 1'b1; cyc();
    repeat (16) begin chk("cleared_buf", 32'(digit_code), 32'h0); cyc(); end

    // Two-symbol message, then shrink to one, then to zero.
    stop = 1'b1; cyc();
    wr(0, 7); wr(1, 9); set_len(2);
    start = 1'b1; cyc();
    chk("l2_s0", 32'(digit_code), 32'd9);
    repeat (4) cyc(); chk("l2_s1", 32'(digit_code), 32'd7);
    repeat (4) cyc(); chk("l2_s2", 32'(digit_code), 32'd9);
    repeat (4) cyc(); chk("l2_s3", 32'(digit_code), 32'd7);
    repeat (60) cyc();
    set_len(1);
    chk("shrink_no_wrap", 32'(wrap), 32'h0);
    repeat (8) cyc();
    repeat (16) begin chk("len1_code", 32'(digit_code), 32'd7); cyc(); end
    set_len(0);
    chk("len0_an", 32'(an), 32'hF);
    chk("len0_running", 32'(running), 32'h0);

    // start+stop together, start with empty message.
    set_len(3);
    start = 1'b1; stop = 1'b1; cyc();
    chk("startstop_running", 32'(running), 32'h0);
    set_len(0);
    start = 1'b1; cyc();
    chk("start_len0_running", 32'(running), 32'h0);

    // Oversized length clamps to 16.
    for (int i = 0; i < 16; i++) wr(i, i);
    set_len(20);
    start = 1'b1; cyc();
    nwrap = 0; wrap_at = -1;
    for (int k = 1; k <= 1030; k++) begin
      cyc();
      if (wrap) begin nwrap++; wrap_at = k; end
    end
    chk("clamp_wrap_count", 32'(nwrap), 32'd1);
    chk("clamp_wrap_cycle", 32'(wrap_at), 32'd1024);

    // Randomized traffic against the model.
    repeat (3000) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 4'($urandom_range(0, 15));
      len_we   = ($urandom_range(0, 39) == 0);
      len_data = 5'($urandom_range(0, 20));
      start    = ($urandom_range(0, 29) == 0);
      stop     = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) hold = ~hold;
      cyc();
    end
    hold = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
